adc_channel_pack: RTL and testbench
===================================

// Module: adc_channel_pack
// PURPOSE
//  Downstream data-path stage of the generic ADC core, in the adc_clk domain.
//  - Takes one sample per channel per adc_valid.
//  - Keeps only the channels set in adc_enable (driven by the per-channel register banks).
//  - Packs those samples into full-width words and buffers them in a sync FIFO for the DMA.
//  - On a drop, drives adc_dovf, which returns to the common register bank as the overflow status.
// PARAMETERS
//  NUM_OF_CHANNELS  2  channel count; power of two, 1..8
//  DATA_WIDTH       16 bits per channel sample
//  FIFO_ADDR_WIDTH  4  FIFO depth = 2**FIFO_ADDR_WIDTH words
// PORTS
//  adc_clk     in   1                  single clock for the whole block
//  adc_rst     in   1                  synchronous, active-high reset
//  adc_enable  in   NUM_OF_CHANNELS    per-channel enable
//  adc_valid   in   1                  adc_data holds one sample of every channel
//  adc_data    in   NUM*DATA_WIDTH     lane k holds channel k
//  dma_valid   out  1                  dma_data valid
//  dma_data    out  NUM*DATA_WIDTH     packed word; lane 0 is the oldest sample
//  dma_ready   in   1                  consumer accepts when valid&&ready
//  adc_dovf    out  1                  1-cycle pulse per dropped word
// BEHAVIOUR
//  Reset: all outputs 0, packer fill=0, FIFO empty, packer lanes zeroed.
//  adc_rst asserted mid-transfer discards the partial word and all FIFO contents.
//  Compaction (per adc_valid):
//  - cnt = popcount(adc_enable).
//  - Enabled samples are compacted in ascending channel order into lanes fill..fill+cnt-1.
//  - fill advances by cnt.
//  Word completion:
//  - Word is complete when fill+cnt == NUM; it is pushed to the FIFO in the next cycle.
//  - If fill+cnt > NUM (only possible for a non-power-of-two cnt), the current word is first
//    pushed with its unfilled upper lanes = 0; the sample set then starts a new word at lane 0.
//    The push and the new-word start happen in the same cycle.
//  cnt == 0: adc_valid is ignored; no push, no dovf.
//  Any adc_enable change (compared against the registered previous value):
//  - Partial word discarded, fill=0.
//  - The sample on that same cycle is packed under the NEW enable set.
//  FIFO:
//  - Registered output, first-word-fall-through.
//  - Latency from the cycle the completing sample is presented to dma_valid high is 2 cycles
//    when the FIFO was empty.
//  - Push and pop in the same cycle with the FIFO full is legal: the pop frees the slot, so no drop.
//  Overflow: a push with the FIFO full and no pop drops the new word (FIFO unchanged).
//  - adc_dovf=1 in that cycle only.
//  - The packer continues with the next word; it does not stall.
//  Handshake:
//  - dma_data is stable while dma_valid && !dma_ready.
//  - dma_valid falls only after the last word is popped.
//  Pointers wrap modulo depth, with an extra MSB for full/empty.
//  - full: ptrs differ only in MSB.
//  - empty: ptrs equal.
// CONFIGURATION
//  ADC_CHANNEL_PACK_DROP_CNT_EN
//  - Defined: adds output adc_drop_count [31:0], the number of dropped words.
//    - Saturates at 32'hFFFFFFFF and clears on adc_rst.
//    - Increments in the same cycle adc_dovf pulses; visible the next cycle.
//  - Undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package adc_channel_pack_pkg:
//  - popcount function;
//  - FIFO pointer-width constant (FIFO_ADDR_WIDTH+1);
//  - lane-index width clog2(NUM_OF_CHANNELS+1).
//  Sub-module adc_channel_pack_fifo: generic sync FIFO with push/pop, full/empty and registered
//  output, instantiated once. Packer and overflow logic live in the top.
// TESTING
//  1. NUM=2, DW=16, enable=2'b11, samples {B0,A0},{B1,A1}, dma_ready=1
//     -> words 32'hB0A0, then 32'hB1A1, first dma_valid 2 cycles after the first sample.
//  2. enable=2'b10, ch1 samples 0x1111 then 0x2222 -> single word 32'h2222_1111; no word
//     after the first sample alone.
//  3. dma_ready=0, FIFO_ADDR_WIDTH=2, enable=2'b11, 6 sample sets
//     -> 4 words stored, adc_dovf pulses on sets 5 and 6, then draining yields words 1-4 in
//     order; with DROP_CNT_EN, adc_drop_count=2.
//  4. enable=2'b01, one ch0 sample, then enable->2'b11 with {0xBBBB,0xAAAA}
//     -> partial discarded; only word 32'hBBBB_AAAA output.
//  5. NUM=4, enable=4'b0111, two sets {A,B,C}, {D,E,F}
//     -> word {0,C,B,A} pushed when set 2 arrives; set 2 fills lanes 0-2 of the next word.
//  6. adc_rst pulsed for 1 cycle with 3 words in the FIFO and a half-filled packer
//     -> dma_valid=0 next cycle; the next full set produces a fresh word from lane 0.

Source files
------------

// File: rtl/adc_channel_pack_pkg.sv
// adc_channel_pack_pkg: shared helpers for the ADC channel packer (popcount, pointer and lane-index widths)
package adc_channel_pack_pkg;

    function automatic int ptr_w(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int lane_w(input int channels);
        return $clog2(channels + 1);
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        popcount = '0;
        for (int i = 0; i < 8; i++) popcount = popcount + 4'(v[i]);
    endfunction

endpackage

// File: rtl/adc_channel_pack_if.sv
// adc_channel_pack_if: sample input, DMA output and overflow status of the channel packer
interface adc_channel_pack_if #(
    parameter int NUM_OF_CHANNELS = 2,
    parameter int DATA_WIDTH      = 16
);
    logic [NUM_OF_CHANNELS-1:0]            adc_enable;
    logic                                  adc_valid;
    logic [NUM_OF_CHANNELS*DATA_WIDTH-1:0] adc_data;
    logic                                  dma_valid;
    logic [NUM_OF_CHANNELS*DATA_WIDTH-1:0] dma_data;
    logic                                  dma_ready;
    logic                                  adc_dovf;

    modport master (
        output adc_enable, adc_valid, adc_data, dma_ready,
        input  dma_valid, dma_data, adc_dovf
    );

    modport slave (
        input  adc_enable, adc_valid, adc_data, dma_ready,
        output dma_valid, dma_data, adc_dovf
    );
endinterface

// File: rtl/adc_channel_pack_fifo.sv
// adc_channel_pack_fifo: sync FIFO with first-word-fall-through registered output
module adc_channel_pack_fifo
    import adc_channel_pack_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);
    localparam int PW    = ptr_w(ADDR_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd, wr, rd_next, wr_next;
    logic             empty, rd_en, wr_en;

    // Pointer arithmetic; a pop frees the slot so a push into a full FIFO is accepted
    always_comb begin
        empty   = rd == wr;
        full    = (rd ^ wr) == {1'b1, {ADDR_WIDTH{1'b0}}};
        rd_en   = pop && !empty;
        wr_en   = push && (!full || rd_en);
        rd_next = rd + PW'(rd_en);
        wr_next = wr + PW'(wr_en);
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr[ADDR_WIDTH-1:0]] <= din;
    end

    // Pointers and output register; a word written into an empty FIFO bypasses straight to dout
    always_ff @(posedge clk) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            valid <= 1'b0;
            dout  <= '0;
        end else begin
            rd    <= rd_next;
            wr    <= wr_next;
            valid <= rd_next != wr_next;
            dout  <= (wr_en && rd_next == wr) ? din : mem[rd_next[ADDR_WIDTH-1:0]];
        end
    end
endmodule

// File: rtl/adc_channel_pack.sv
// adc_channel_pack: compacts enabled ADC channels into full-width words and buffers them for DMA
// Optional ADC_CHANNEL_PACK_DROP_CNT_EN adds a saturating 32-bit dropped-word counter.
module adc_channel_pack
    import adc_channel_pack_pkg::*;
#(
    parameter int NUM_OF_CHANNELS = 2,
    parameter int DATA_WIDTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input logic adc_clk,
    input logic adc_rst,
    adc_channel_pack_if.slave bus
`ifdef ADC_CHANNEL_PACK_DROP_CNT_EN
    ,
    output logic [31:0] adc_drop_count
`endif
);
    localparam int W  = NUM_OF_CHANNELS * DATA_WIDTH;
    localparam int LW = lane_w(NUM_OF_CHANNELS);

    logic [NUM_OF_CHANNELS-1:0] prev_enable;
    logic [LW-1:0]              fill, fill_next, start, k;
    logic [W-1:0]               buffer, buffer_next, comp, base, word;
    logic [W-1:0]               push_data, push_data_next;
    logic                       push, push_next, changed, take, full, pop, dovf;
    logic [3:0]                 cnt;
    int                         sum;

    // Gather enabled channel samples into the low lanes in ascending channel order
    always_comb begin
        comp = '0;
        k    = '0;
        for (int i = 0; i < NUM_OF_CHANNELS; i++) begin
            if (bus.adc_enable[i]) begin
                comp[int'(k)*DATA_WIDTH +: DATA_WIDTH] = bus.adc_data[i*DATA_WIDTH +: DATA_WIDTH];
                k = k + LW'(1);
            end
        end
    end

    // Packer next state: an enable change restarts the word; an overflowing set flushes the partial word
    always_comb begin
        changed        = bus.adc_enable != prev_enable;
        cnt            = popcount(8'(bus.adc_enable));
        take           = bus.adc_valid && cnt != 0;
        base           = changed ? '0 : buffer;
        start          = changed ? '0 : fill;
        sum            = int'(start) + int'(cnt);
        word           = base | (comp << (int'(start) * DATA_WIDTH));
        push_next      = take && sum >= NUM_OF_CHANNELS;
        push_data_next = sum > NUM_OF_CHANNELS ? base : word;
        buffer_next    = !take ? base : sum == NUM_OF_CHANNELS ? '0 : sum > NUM_OF_CHANNELS ? comp : word;
        fill_next      = !take ? start : sum == NUM_OF_CHANNELS ? '0 :
                         sum > NUM_OF_CHANNELS ? LW'(cnt) : LW'(sum);
    end

    // Packer registers and the one-cycle push stage into the FIFO
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            prev_enable <= '0;
            fill        <= '0;
            buffer      <= '0;
            push        <= 1'b0;
            push_data   <= '0;
        end else begin
            prev_enable <= bus.adc_enable;
            fill        <= fill_next;
            buffer      <= buffer_next;
            push        <= push_next;
            push_data   <= push_data_next;
        end
    end

    assign pop          = bus.dma_valid && bus.dma_ready;
    assign dovf         = push && full && !pop;
    assign bus.adc_dovf = dovf;

    adc_channel_pack_fifo #(
        .WIDTH     (W),
        .ADDR_WIDTH(FIFO_ADDR_WIDTH)
    ) fifo (
        .clk  (adc_clk),
        .rst  (adc_rst),
        .push (push),
        .din  (push_data),
        .pop  (pop),
        .dout (bus.dma_data),
        .valid(bus.dma_valid),
        .full (full)
    );

`ifdef ADC_CHANNEL_PACK_DROP_CNT_EN
    // Saturating count of dropped words
    always_ff @(posedge adc_clk) begin
        if (adc_rst) adc_drop_count <= '0;
        else if (dovf && adc_drop_count != '1) adc_drop_count <= adc_drop_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_adc_channel_pack.sv
// tb_adc_channel_pack: directed and randomized checks of adc_channel_pack (2- and 4-channel builds)
module tb_adc_channel_pack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   dovf2 = 0;
    logic [31:0] got2[$];
    logic [63:0] got4[$];

    adc_channel_pack_if #(.NUM_OF_CHANNELS(2), .DATA_WIDTH(16)) b2 ();
    adc_channel_pack_if #(.NUM_OF_CHANNELS(4), .DATA_WIDTH(16)) b4 ();

`ifdef ADC_CHANNEL_PACK_DROP_CNT_EN
    logic [31:0] drop2, drop4;
`endif

    adc_channel_pack #(.NUM_OF_CHANNELS(2), .DATA_WIDTH(16), .FIFO_ADDR_WIDTH(2)) dut2 (
        .adc_clk(clk),
        .adc_rst(rst),
        .bus    (b2)
`ifdef ADC_CHANNEL_PACK_DROP_CNT_EN
        ,
        .adc_drop_count(drop2)
`endif
    );

    adc_channel_pack #(.NUM_OF_CHANNELS(4), .DATA_WIDTH(16), .FIFO_ADDR_WIDTH(2)) dut4 (
        .adc_clk(clk),
        .adc_rst(rst),
        .bus    (b4)
`ifdef ADC_CHANNEL_PACK_DROP_CNT_EN
        ,
        .adc_drop_count(drop4)
`endif
    );

    always #5 clk = ~clk;

    // Record accepted words and overflow pulses mid-cycle
    always @(negedge clk) begin
        if (b2.dma_valid && b2.dma_ready) got2.push_back(b2.dma_data);
        if (b4.dma_valid && b4.dma_ready) got4.push_back(b4.dma_data);
        if (b2.adc_dovf) dovf2++;
    end

    function automatic logic [31:0] w2(input int i);
        return {16'hB000 | 16'(i), 16'hA000 | 16'(i)};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_all();
        rst = 1'b1;
        b2.adc_valid = 1'b0;
        b4.adc_valid = 1'b0;
        tick(1);
        rst = 1'b0;
        got2.delete();
        got4.delete();
        dovf2 = 0;
    endtask

    task automatic set2(input logic [1:0] en, input logic [31:0] d);
        b2.adc_enable = en;
        b2.adc_valid  = 1'b1;
        b2.adc_data   = d;
        tick(1);
        b2.adc_valid  = 1'b0;
    endtask

    task automatic set4(input logic [3:0] en, input logic [63:0] d);
        b4.adc_enable = en;
        b4.adc_valid  = 1'b1;
        b4.adc_data   = d;
        tick(1);
        b4.adc_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset_all();
        n_checks++;
        if (b2.dma_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid2: got %b expected 0", b2.dma_valid); end
        n_checks++;
        if (b2.dma_data !== 32'h0) begin n_fail++; $display("FAIL reset_data2: got %h expected 0", b2.dma_data); end
        n_checks++;
        if (b2.adc_dovf !== 1'b0) begin n_fail++; $display("FAIL reset_dovf2: got %b expected 0", b2.adc_dovf); end
        n_checks++;
        if (b4.dma_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid4: got %b expected 0", b4.dma_valid); end
`ifdef ADC_CHANNEL_PACK_DROP_CNT_EN
        n_checks++;
        if (drop2 !== 32'd0) begin n_fail++; $display("FAIL reset_drop2: got %0d expected 0", drop2); end
`endif
    endtask

    task automatic test_basic();
        reset_all();
        b2.dma_ready = 1'b1;
        set2(2'b11, 32'hB0B0_A0A0);
        n_checks++;
        if (b2.dma_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", b2.dma_valid); end
        set2(2'b11, 32'hB1B1_A1A1);
        n_checks++;
        if (b2.dma_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b expected 1", b2.dma_valid); end
        n_checks++;
        if (b2.dma_data !== 32'hB0B0_A0A0) begin n_fail++; $display("FAIL basic_first: got %h expected b0b0a0a0", b2.dma_data); end
        tick(3);
        n_checks++;
        if (got2.size() != 2 || got2[0] !== 32'hB0B0_A0A0 || got2[1] !== 32'hB1B1_A1A1) begin
            n_fail++; $display("FAIL basic_words: got %p expected b0b0a0a0,b1b1a1a1", got2);
        end
    endtask

    task automatic test_single_channel();
        reset_all();
        b2.dma_ready = 1'b1;
        set2(2'b10, 32'h1111_DEAD);
        tick(3);
        n_checks++;
        if (got2.size() != 0) begin n_fail++; $display("FAIL single_no_word: got %0d words expected 0", got2.size()); end
        set2(2'b10, 32'h2222_BEEF);
        tick(4);
        n_checks++;
        if (got2.size() != 1 || got2[0] !== 32'h2222_1111) begin
            n_fail++; $display("FAIL single_word: got %p expected 22221111", got2);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] held;
        reset_all();
        b2.dma_ready = 1'b0;
        for (int i = 1; i <= 6; i++) set2(2'b11, w2(i));
        tick(3);
        n_checks++;
        if (dovf2 != 2) begin n_fail++; $display("FAIL ovf_pulses: got %0d expected 2", dovf2); end
`ifdef ADC_CHANNEL_PACK_DROP_CNT_EN
        n_checks++;
        if (drop2 !== 32'd2) begin n_fail++; $display("FAIL ovf_drop_count: got %0d expected 2", drop2); end
`endif
        held = b2.dma_data;
        n_checks++;
        if (b2.dma_valid !== 1'b1 || held !== w2(1)) begin
            n_fail++; $display("FAIL ovf_head: got valid=%b data=%h expected 1 %h", b2.dma_valid, held, w2(1));
        end
        tick(2);
        n_checks++;
        if (b2.dma_data !== w2(1)) begin n_fail++; $display("FAIL ovf_stable: got %h expected %h", b2.dma_data, w2(1)); end
        b2.dma_ready = 1'b1;
        tick(6);
        n_checks++;
        if (got2.size() != 4) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected 4", got2.size()); end
        for (int i = 0; i < got2.size() && i < 4; i++) begin
            n_checks++;
            if (got2[i] !== w2(i + 1)) begin n_fail++; $display("FAIL ovf_drain_word%0d: got %h expected %h", i, got2[i], w2(i + 1)); end
        end
        n_checks++;
        if (b2.dma_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b expected 0", b2.dma_valid); end
    endtask

    task automatic test_full_push_pop();
        reset_all();
        b2.dma_ready = 1'b0;
        for (int i = 1; i <= 4; i++) set2(2'b11, w2(i));
        tick(1);
        set2(2'b11, w2(5));
        b2.dma_ready = 1'b1;
        tick(1);
        b2.dma_ready = 1'b0;
        tick(2);
        n_checks++;
        if (dovf2 != 0) begin n_fail++; $display("FAIL pushpop_dovf: got %0d expected 0", dovf2); end
        b2.dma_ready = 1'b1;
        tick(6);
        n_checks++;
        if (got2.size() != 5) begin n_fail++; $display("FAIL pushpop_count: got %0d expected 5", got2.size()); end
        for (int i = 0; i < got2.size() && i < 5; i++) begin
            n_checks++;
            if (got2[i] !== w2(i + 1)) begin n_fail++; $display("FAIL pushpop_word%0d: got %h expected %h", i, got2[i], w2(i + 1)); end
        end
    endtask

    task automatic test_enable_change();
        reset_all();
        b2.dma_ready = 1'b1;
        set2(2'b01, 32'h0000_5555);
        set2(2'b11, 32'hBBBB_AAAA);
        tick(4);
        n_checks++;
        if (got2.size() != 1 || got2[0] !== 32'hBBBB_AAAA) begin
            n_fail++; $display("FAIL enchg_words: got %p expected bbbbaaaa", got2);
        end
    endtask

    task automatic test_reset_mid();
        reset_all();
        b2.dma_ready = 1'b0;
        for (int i = 1; i <= 3; i++) set2(2'b11, w2(i));
        set2(2'b01, 32'h0000_7777);
        tick(2);
        n_checks++;
        if (b2.dma_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 1", b2.dma_valid); end
        reset_all();
        n_checks++;
        if (b2.dma_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", b2.dma_valid); end
        b2.dma_ready = 1'b1;
        set2(2'b11, 32'hCCCC_DDDD);
        tick(4);
        n_checks++;
        if (got2.size() != 1 || got2[0] !== 32'hCCCC_DDDD) begin
            n_fail++; $display("FAIL rstmid_words: got %p expected ccccdddd", got2);
        end
    endtask

    task automatic test_three_of_four();
        reset_all();
        b4.dma_ready = 1'b1;
        set4(4'b0111, 64'h9999_CCCC_BBBB_AAAA);
        tick(3);
        n_checks++;
        if (got4.size() != 0) begin n_fail++; $display("FAIL three_no_word: got %0d expected 0", got4.size()); end
        set4(4'b0111, 64'h9999_FFFF_EEEE_DDDD);
        tick(3);
        n_checks++;
        if (got4.size() != 1 || got4[0] !== 64'h0000_CCCC_BBBB_AAAA) begin
            n_fail++; $display("FAIL three_first: got %p expected 0000ccccbbbbaaaa", got4);
        end
        set4(4'b0111, 64'h9999_3333_2222_1111);
        tick(3);
        n_checks++;
        if (got4.size() != 2 || got4[1] !== 64'h0000_FFFF_EEEE_DDDD) begin
            n_fail++; $display("FAIL three_second: got %p expected 0000ffffeeeedddd", got4);
        end
    endtask

    task automatic test_random();
        logic [63:0] mq[$];
        logic [15:0] part[$];
        logic [63:0] pend, d;
        logic        pend_v, exp_valid, exp_dovf, rdy, v;
        logic [3:0]  en, prev_en;
        int          drops;
        reset_all();
        pend = '0;
        pend_v = 1'b0;
        prev_en = '0;
        en = 4'b1111;
        drops = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) en = 4'($urandom_range(0, 15));
            v = $urandom_range(0, 3) != 0;
            d = {$urandom, $urandom};
            rdy = $urandom_range(0, 99) < (((i / 100) % 2 == 0) ? 25 : 85);
            b4.adc_enable = en;
            b4.adc_valid  = v;
            b4.adc_data   = d;
            b4.dma_ready  = rdy;
            #1;
            exp_valid = mq.size() > 0;
            exp_dovf  = pend_v && mq.size() == 4 && !(exp_valid && rdy);
            n_checks++;
            if (b4.dma_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid@%0d: got %b expected %b", i, b4.dma_valid, exp_valid); end
            n_checks++;
            if (b4.adc_dovf !== exp_dovf) begin n_fail++; $display("FAIL rand_dovf@%0d: got %b expected %b", i, b4.adc_dovf, exp_dovf); end
            if (exp_valid) begin
                n_checks++;
                if (b4.dma_data !== mq[0]) begin n_fail++; $display("FAIL rand_data@%0d: got %h expected %h", i, b4.dma_data, mq[0]); end
            end
            if (exp_valid && rdy) void'(mq.pop_front());
            if (pend_v) begin
                if (mq.size() < 4) mq.push_back(pend);
                else drops++;
            end
            pend_v = 1'b0;
            if (en != prev_en) part.delete();
            if (v && $countones(en) > 0) begin
                if (part.size() + $countones(en) > 4) begin
                    pend = '0;
                    foreach (part[k]) pend[k*16 +: 16] = part[k];
                    pend_v = 1'b1;
                    part.delete();
                end
                for (int c = 0; c < 4; c++) if (en[c]) part.push_back(d[c*16 +: 16]);
                if (part.size() == 4) begin
                    pend = '0;
                    foreach (part[k]) pend[k*16 +: 16] = part[k];
                    pend_v = 1'b1;
                    part.delete();
                end
            end
            prev_en = en;
            @(posedge clk);
            #1;
        end
        b4.adc_valid = 1'b0;
`ifdef ADC_CHANNEL_PACK_DROP_CNT_EN
        n_checks++;
        if (drop4 !== 32'(drops)) begin n_fail++; $display("FAIL rand_drop_count: got %0d expected %0d", drop4, drops); end
`endif
    endtask

    initial begin
        b2.adc_enable = '0; b2.adc_valid = 1'b0; b2.adc_data = '0; b2.dma_ready = 1'b0;
        b4.adc_enable = '0; b4.adc_valid = 1'b0; b4.adc_data = '0; b4.dma_ready = 1'b0;
        tick(2);
        test_reset();
        test_basic();
        test_single_channel();
        test_overflow();
        test_full_push_pop();
        test_enable_change();
        test_reset_mid();
        test_three_of_four();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
